// File: rtl/if_id_hazard_stage_if.sv
// ---------------------------------------------------------------------------
// if_id_hazard_stage_if
//
// Signal bundle between the IF/ID hazard stage and its neighbours: fetch,
// decode and the EX stage.
//
//   Fetch -> stage   : Instruction, PC_IF
//   EX    -> stage   : ID_EX_MemRead, ID_EX_Rt, branch_taken_ex,
//                      branch_target_ex
//   stage -> decode  : Instruction_ID, PC_ID, PC_plus4_ID, valid_ID
//   stage -> fetch   : pc_hold, PC_source, PC_Jump
//   stage -> ID/EX   : bubble_ID
//   stage -> perf    : stall_count (CNT_WIDTH bits, saturating)
//
// The "master" modport is the surrounding pipeline, which drives the fetch and
// EX inputs. The "slave" modport is the stage itself.
// ---------------------------------------------------------------------------
interface if_id_hazard_stage_if #(
    parameter int CNT_WIDTH = 16
);
    logic [31:0]          Instruction;
    logic [31:0]          PC_IF;
    logic                 ID_EX_MemRead;
    logic [4:0]           ID_EX_Rt;
    logic                 branch_taken_ex;
    logic [31:0]          branch_target_ex;

    logic [31:0]          Instruction_ID;
    logic [31:0]          PC_ID;
    logic [31:0]          PC_plus4_ID;
    logic                 valid_ID;
    logic                 pc_hold;
    logic                 PC_source;
    logic [31:0]          PC_Jump;
    logic                 bubble_ID;
    logic [CNT_WIDTH-1:0] stall_count;

    modport master (
        output Instruction, PC_IF, ID_EX_MemRead, ID_EX_Rt,
               branch_taken_ex, branch_target_ex,
        input  Instruction_ID, PC_ID, PC_plus4_ID, valid_ID,
               pc_hold, PC_source, PC_Jump, bubble_ID, stall_count
    );

    modport slave (
        input  Instruction, PC_IF, ID_EX_MemRead, ID_EX_Rt,
               branch_taken_ex, branch_target_ex,
        output Instruction_ID, PC_ID, PC_plus4_ID, valid_ID,
               pc_hold, PC_source, PC_Jump, bubble_ID, stall_count
    );
endinterface

// File: rtl/if_id_hazard_stage.sv
// ---------------------------------------------------------------------------
// if_id_hazard_stage
//
// The IF/ID pipeline register of the 5-stage MIPS pipeline, combined with the
// decode-side hazard and redirect control.
//   - It captures the fetched instruction, its PC and PC+4.
//   - It stalls fetch for one cycle on a load-use hazard and asks ID/EX for a
//     bubble.
//   - It redirects fetch on an unconditional jump in ID (j/jal) and squashes
//     the wrong-path fetch.
//   - It redirects fetch on a taken branch from EX and flushes the slot.
//   - It counts load-use stall cycles in a saturating counter.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   bus    : if_id_hazard_stage_if.slave. It carries the fetch and EX inputs,
//            the registered ID outputs, and the combinational controls
//            (pc_hold, PC_source, PC_Jump, bubble_ID).
//
// The action priority in each cycle is:
//   reset > taken branch > load-use > jump > normal advance.
// ---------------------------------------------------------------------------
module if_id_hazard_stage #(
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    if_id_hazard_stage_if.slave   bus
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_BRANCH,
        ACT_STALL,
        ACT_JUMP,
        ACT_ADVANCE
    } action_e;

    // Opcodes whose rt field is a source operand rather than a destination.
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_SW);
    endfunction

    // The counter holds at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_WIDTH'(1);
    endfunction

    logic [31:0]          instr_q, instr_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          pc4_q, pc4_d;
    logic                 valid_q, valid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       lu;
    logic       jmp;
    action_e    act;

    // Decode and hazard detection on the registered ID instruction.
    // A flushed slot (valid_q == 0) never raises a hazard or a jump.
    always_comb begin
        op  = instr_q[31:26];
        rs  = instr_q[25:21];
        rt  = instr_q[20:16];
        lu  = valid_q && bus.ID_EX_MemRead && (bus.ID_EX_Rt != 5'd0) &&
              ((bus.ID_EX_Rt == rs) || (reads_rt(op) && (bus.ID_EX_Rt == rt)));
        jmp = valid_q && ((op == OP_J) || (op == OP_JAL));
    end

    always_comb begin
        act = ACT_ADVANCE;
        if (reset) begin
            act = ACT_RESET;
        end else if (bus.branch_taken_ex) begin
            act = ACT_BRANCH;
        end else if (lu) begin
            act = ACT_STALL;
        end else if (jmp) begin
            act = ACT_JUMP;
        end
    end

    // Controls back to fetch and to ID/EX. They are forced to 0 while reset
    // is high, so that reset also masks a redirect raised in the same cycle.
    always_comb begin
        bus.pc_hold   = 1'b0;
        bus.PC_source = 1'b0;
        bus.PC_Jump   = 32'h0000_0000;
        bus.bubble_ID = 1'b0;
        unique case (act)
            ACT_BRANCH: begin
                bus.PC_source = 1'b1;
                bus.PC_Jump   = bus.branch_target_ex;
                bus.bubble_ID = 1'b1;
            end
            ACT_STALL: begin
                bus.pc_hold   = 1'b1;
                bus.bubble_ID = 1'b1;
            end
            ACT_JUMP: begin
                // Keep the jump in ID (no bubble) so jal can still link.
                bus.PC_source = 1'b1;
                bus.PC_Jump   = {pc4_q[31:28], instr_q[25:0], 2'b00};
            end
            default: ;
        endcase
    end

    // Next-state selection. The default is to hold the current contents,
    // which is what a load-use stall needs.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        unique case (act)
            ACT_RESET: begin
                instr_d = NOP_WORD;
                pc_d    = 32'h0000_0000;
                pc4_d   = 32'h0000_0000;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
            ACT_BRANCH: begin
                // The branch flushes the slot. PC/PC+4 are cleared because
                // nothing downstream may rely on a squashed PC.
                instr_d = NOP_WORD;
                pc_d    = 32'h0000_0000;
                pc4_d   = 32'h0000_0000;
                valid_d = 1'b0;
            end
            ACT_STALL: begin
                cnt_d = sat_inc(cnt_q);
            end
            ACT_JUMP: begin
                // Squash the sequential fetch that follows the jump. PC/PC+4
                // keep their values; only the instruction and valid change.
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end
            default: begin
                instr_d = bus.Instruction;
                pc_d    = bus.PC_IF;
                pc4_d   = bus.PC_IF + 32'd4;
                valid_d = 1'b1;
            end
        endcase
    end

    // ---- IF/ID register boundary ----
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= NOP_WORD;
            pc_q    <= 32'h0000_0000;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.Instruction_ID = instr_q;
    assign bus.PC_ID          = pc_q;
    assign bus.PC_plus4_ID    = pc4_q;
    assign bus.valid_ID       = valid_q;
    assign bus.stall_count    = cnt_q;

endmodule
